// File: rtl/synth_pkg.sv
// Shared types and constants for the synth voice path: frequency width,
// power-on frequency, allocator FSM states, slot commands and voice record.
package synth_pkg;

  localparam int          FREQ_W       = 12;
  localparam int          AGE_W        = 8;
  localparam int unsigned DEFAULT_FREQ = 440;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } state_e;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_WRITE,
    CMD_RETRIG,
    CMD_RELEASE,
    CMD_AGE
  } slot_cmd_e;

  typedef struct packed {
    logic [FREQ_W-1:0] freq;
    logic              gate;
    logic [AGE_W-1:0]  age;
  } voice_t;

endpackage

// File: rtl/voice_slot.sv
// One oscillator voice: frequency, gate and age registers updated by
// commands from the allocator FSM. Age saturates at all-ones.
// The age output exists only when VOICE_STEAL_EN is defined.
module voice_slot #(
  parameter int FREQ_W = 12,
  parameter int AGE_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  synth_pkg::slot_cmd_e cmd,
  input  logic [FREQ_W-1:0]    wr_freq,
  output logic [FREQ_W-1:0]    freq,
  output logic                 gate
`ifdef VOICE_STEAL_EN
  ,
  output logic [AGE_W-1:0]     age
`endif
);
  import synth_pkg::*;

  logic [FREQ_W-1:0] freq_q, freq_d;
  logic              gate_q, gate_d;
  logic [AGE_W-1:0]  age_q, age_d;

  // Apply the command for this cycle; ungated voices never accumulate age.
  always_comb begin
    freq_d = freq_q;
    gate_d = gate_q;
    age_d  = age_q;
    case (cmd)
      CMD_WRITE: begin
        freq_d = wr_freq;
        gate_d = 1'b1;
        age_d  = '0;
      end
      CMD_RETRIG: begin
        gate_d = 1'b1;
        age_d  = '0;
      end
      CMD_RELEASE: begin
        gate_d = 1'b0;
        age_d  = '0;
      end
      CMD_AGE: begin
        if (gate_q && (age_q != '1)) age_d = age_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Voice registers; reset leaves the oscillator on its default pitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freq_q <= FREQ_W'(DEFAULT_FREQ);
      gate_q <= 1'b0;
      age_q  <= '0;
    end else begin
      freq_q <= freq_d;
      gate_q <= gate_d;
      age_q  <= age_d;
    end
  end

  assign freq = freq_q;
  assign gate = gate_q;
`ifdef VOICE_STEAL_EN
  assign age  = age_q;
`endif

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: accepts note-on/off events, scans the voice
// bank one slot per cycle, then commits a retrigger, allocation, release,
// steal or drop. Optional macro VOICE_STEAL_EN enables stealing the oldest
// voice when the bank is full; otherwise such note-ons are dropped.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int FREQ_W     = 12,
  parameter int AGE_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ev_valid,
  output logic                         ev_ready,
  input  logic                         ev_on,
  input  logic [FREQ_W-1:0]            ev_freq,
  output logic [NUM_VOICES*FREQ_W-1:0] voice_freq,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic                         dropped
);
  import synth_pkg::*;

  localparam int               IDX_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              on_q, on_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic              match_vld_q, match_vld_d;
  logic [IDX_W-1:0]  match_idx_q, match_idx_d;
  logic              free_vld_q, free_vld_d;
  logic [IDX_W-1:0]  free_idx_q, free_idx_d;
  logic              dropped_q, dropped_d;
`ifdef VOICE_STEAL_EN
  logic              old_vld_q, old_vld_d;
  logic [IDX_W-1:0]  old_idx_q, old_idx_d;
  logic [AGE_W-1:0]  old_age_q, old_age_d;
  logic [AGE_W-1:0]  slot_age [NUM_VOICES];
`endif

  slot_cmd_e         slot_cmd  [NUM_VOICES];
  logic [FREQ_W-1:0] slot_freq [NUM_VOICES];
  logic              slot_gate [NUM_VOICES];
  logic [IDX_W-1:0]  tgt;
  slot_cmd_e         tcmd;
  logic              hit;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    voice_slot #(
      .FREQ_W (FREQ_W),
      .AGE_W  (AGE_W)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .cmd     (slot_cmd[g]),
      .wr_freq (freq_q),
      .freq    (slot_freq[g]),
      .gate    (slot_gate[g])
`ifdef VOICE_STEAL_EN
      ,
      .age     (slot_age[g])
`endif
    );
    assign voice_freq[g*FREQ_W +: FREQ_W] = slot_freq[g];
    assign voice_gate[g]                  = slot_gate[g];
  end

  assign ev_ready = (state_q == IDLE);
  assign dropped  = dropped_q;

  // Next-state, scan bookkeeping and per-slot command generation.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    on_d        = on_q;
    freq_d      = freq_q;
    match_vld_d = match_vld_q;
    match_idx_d = match_idx_q;
    free_vld_d  = free_vld_q;
    free_idx_d  = free_idx_q;
`ifdef VOICE_STEAL_EN
    old_vld_d   = old_vld_q;
    old_idx_d   = old_idx_q;
    old_age_d   = old_age_q;
`endif
    dropped_d   = 1'b0;
    tgt         = '0;
    tcmd        = CMD_NONE;
    hit         = 1'b0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) slot_cmd[i] = CMD_NONE;

    case (state_q)
      IDLE: begin
        if (ev_valid) begin
          state_d     = SCAN;
          on_d        = ev_on;
          freq_d      = ev_freq;
          idx_d       = '0;
          match_vld_d = 1'b0;
          free_vld_d  = 1'b0;
`ifdef VOICE_STEAL_EN
          old_vld_d   = 1'b0;
`endif
        end
      end
      SCAN: begin
        if (slot_gate[idx_q] && (slot_freq[idx_q] == freq_q) && !match_vld_q) begin
          match_vld_d = 1'b1;
          match_idx_d = idx_q;
        end
        if (!slot_gate[idx_q] && !free_vld_q) begin
          free_vld_d = 1'b1;
          free_idx_d = idx_q;
        end
`ifdef VOICE_STEAL_EN
        // Strictly-greater compare keeps the lowest index on age ties.
        if (slot_gate[idx_q] && (!old_vld_q || (slot_age[idx_q] > old_age_q))) begin
          old_vld_d = 1'b1;
          old_idx_d = idx_q;
          old_age_d = slot_age[idx_q];
        end
`endif
        if (idx_q == LAST_IDX) state_d = COMMIT;
        else                   idx_d   = idx_q + 1'b1;
      end
      COMMIT: begin
        state_d = IDLE;
        if (on_q) begin
          if (freq_q == '0) begin
            dropped_d = 1'b1;
          end else if (match_vld_q) begin
            hit  = 1'b1;
            tgt  = match_idx_q;
            tcmd = CMD_RETRIG;
          end else if (free_vld_q) begin
            hit  = 1'b1;
            tgt  = free_idx_q;
            tcmd = CMD_WRITE;
          end else begin
`ifdef VOICE_STEAL_EN
            hit  = 1'b1;
            tgt  = old_idx_q;
            tcmd = CMD_WRITE;
`else
            dropped_d = 1'b1;
`endif
          end
          // Target gets its command; every other slot ages (slot ignores if ungated).
          if (hit) begin
            for (int unsigned i = 0; i < NUM_VOICES; i++)
              slot_cmd[i] = (IDX_W'(i) == tgt) ? tcmd : CMD_AGE;
          end
        end else if (match_vld_q) begin
          slot_cmd[match_idx_q] = CMD_RELEASE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and latched-event registers; reset aborts any event in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      on_q        <= 1'b0;
      freq_q      <= '0;
      match_vld_q <= 1'b0;
      match_idx_q <= '0;
      free_vld_q  <= 1'b0;
      free_idx_q  <= '0;
      dropped_q   <= 1'b0;
`ifdef VOICE_STEAL_EN
      old_vld_q   <= 1'b0;
      old_idx_q   <= '0;
      old_age_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      on_q        <= on_d;
      freq_q      <= freq_d;
      match_vld_q <= match_vld_d;
      match_idx_q <= match_idx_d;
      free_vld_q  <= free_vld_d;
      free_idx_q  <= free_idx_d;
      dropped_q   <= dropped_d;
`ifdef VOICE_STEAL_EN
      old_vld_q   <= old_vld_d;
      old_idx_q   <= old_idx_d;
      old_age_q   <= old_age_d;
`endif
    end
  end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice allocator that shares a fixed bank of square-wave oscillators between incoming note events. It sits between the note/event source and the `osc_square` instances. It accepts note-on/note-off events through a valid/ready handshake and drives a per-voice 12-bit frequency word and gate. Each voice's frequency output connects directly to one oscillator's `freq` input; gates go to the output mixer/envelope.

## Interface
- `NUM_VOICES`, 4: number of oscillator voices managed (2..16).
- `FREQ_W`, 12: frequency word width in Hz; matches the oscillator `freq` input.
- `AGE_W`, 8: per-voice age counter width.

- `clk`  in  1  system clock (1 MHz).
- `rst`  in  1  reset; asynchronous, active-high.
- `ev_valid`  in  1  event present.
- `ev_ready`  out  1  allocator can accept an event.
- `ev_on`  in  1  1 = note-on, 0 = note-off.
- `ev_freq`  in  FREQ_W  note frequency in Hz.
- `voice_freq`  out  NUM_VOICES*FREQ_W  packed per-voice frequency; voice i occupies bits [i*FREQ_W +: FREQ_W].
- `voice_gate`  out  NUM_VOICES  per-voice note-active flag.
- `dropped`  out  1  one-cycle pulse when a note-on is discarded.

## Operation
- FSM states and transitions:
  - IDLE → SCAN on accept.
  - SCAN → COMMIT after the last voice is examined.
  - COMMIT → IDLE.
- Handshake:
  - `ev_ready` = (state == IDLE).
  - An event is accepted on a rising edge with `ev_valid && ev_ready`.
  - `ev_on` and `ev_freq` are latched at accept; the inputs may change afterwards.
- SCAN:
  - Examines voice index 0..NUM_VOICES-1, one voice per cycle.
  - Records: first gated voice whose frequency equals the latched frequency (match), lowest-index ungated voice (free), and gated voice with the largest age (oldest; ties go to the lowest index).
- COMMIT for a note-on, in priority order:
  - Match: retrigger. Frequency unchanged, gate stays 1, age cleared.
  - Else free: write the frequency, set gate, clear age.
  - Else steal oldest (see Configuration).
- Ageing on every successful note-on: all other gated voices increment age, saturating at 2^AGE_W-1. Ungated voices hold age at 0.
- COMMIT for a note-off:
  - The matching gated voice clears its gate and age. Its frequency is retained, so the oscillator keeps running; muting is downstream.
  - No match: no change, no error.
- A note-on with `ev_freq` == 0 is rejected in COMMIT: no voice changes and `dropped` pulses. This protects the oscillator's divide-by-zero.
- Reset values:
  - state IDLE, so `ev_ready` = 1.
  - `voice_gate` = 0.
  - every `voice_freq` = 440.
  - ages 0, `dropped` = 0.
- Reset asserted mid-event aborts the event. All state returns to reset values asynchronously and the event is lost.

## Timing
- Accept on edge T0.
- SCAN occupies NUM_VOICES cycles.
- COMMIT writes `voice_freq`, `voice_gate` and `dropped` on edge T0+NUM_VOICES+1.
- `ev_ready` is high again in the cycle after that edge, so the next accept is possible at T0+NUM_VOICES+2. With NUM_VOICES=4 this is 6 cycles per event.
- `dropped` is high for exactly one cycle, coincident with the COMMIT update.
- Outputs are registered and stable between COMMITs.
- Back-to-back events are throughput-limited by the scan only; no event is lost while `ev_valid` is held.

## Configuration
- `VOICE_STEAL_EN` defined: a note-on with no match and no free voice overwrites the oldest voice. That voice gets the new frequency, gate 1 and age 0; `dropped` stays 0.
- `VOICE_STEAL_EN` undefined: the same event is discarded, no voice changes and `dropped` pulses. The oldest-tracking logic is removed.

## Structure
- Shared package `synth_pkg` holds:
  - `FREQ_W`
  - `DEFAULT_FREQ` = 440
  - the FSM state enum (IDLE, SCAN, COMMIT)
  - the voice record typedef (freq, gate, age)
- Sub-module `voice_slot`, instantiated NUM_VOICES times:
  - Holds one voice's freq/gate/age registers.
  - Applies write/retrigger/release/age-increment commands from the FSM, with saturation.

## Test plan
- Reset, idle 10 cycles → `ev_ready`=1, `voice_gate`=4'b0000, all `voice_freq`=440, `dropped`=0.
- Note-on 262, then note-on 330 (NUM_VOICES=4):
  - voice0=262 with gate 1 at accept+5; voice1=330.
  - `ev_ready` low for exactly 5 cycles per event.
- Note-on 262, 330, 392, 494, then note-on 523:
  - With `VOICE_STEAL_EN`: voice0 becomes 523, gates stay 4'b1111, `dropped`=0.
  - Without it: voices unchanged and `dropped` pulses once.
- Note-on 262, 330, then note-off 262 → `voice_gate`=4'b0010, voice0 frequency still 262. Then note-off 999 → no change.
- Note-on 262 twice → only voice0 gated (retrigger); voice1 untouched.
- Note-on with freq 0 → `dropped` pulse and no gate change. Separately, assert `rst` two cycles into SCAN → all outputs return to reset values immediately and `ev_ready`=1 after release.
